alu_sequencer: RTL and testbench

//  Multi-cycle control unit that drives the 16-bit ALU. Accepts 16-bit instructions over a valid/ready port.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/reg_file.sv | 33 +++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM state encodings plus
// the instruction field positions.
// Optional build macro: TRAP_ON_OVF_EN adds the HALT state.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_INV = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_ASR = 4'd4,
        OP_SLL = 4'd5,
        OP_BEQ = 4'd6,
        OP_BNE = 4'd7,
        OP_XOR = 4'd8
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3
`ifdef TRAP_ON_OVF_EN
        ,
        ST_HALT      = 3'd4
`endif
    } seq_state_e;

    // Instruction layout: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
    // Branches reuse [7:0] as a signed pc offset.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int OFF_MSB = 7;
    localparam int OFF_LSB = 0;

    // Highest opcode the ALU implements; anything above retires as illegal.
    localparam logic [3:0] OP_LAST_LEGAL = OP_XOR;

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 16-entry register file: two asynchronous read ports, one synchronous write
// port. Register 0 always reads zero and ignores writes.
module reg_file #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ra_addr,
    input  logic [3:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [16];

    // Storage: cleared by reset, written on the rising edge when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 4'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == 4'd0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == 4'd0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the external 16-bit ALU. Each accepted
// instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK, four cycles.
// Optional build macro: TRAP_ON_OVF_EN -- an overflowing ADD is not written
// back, pc holds, and the sequencer parks in HALT until reset.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_s,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_take_branch,
    input  logic              alu_ovf,
    output logic              ovf_flag,
    output logic              illegal,
    output logic              halted
);

    seq_state_e        state;
    logic [15:0]       instr_p0;
    logic [DATA_W-1:0] res_p2;
    logic              take_p2;
    logic              ovf_p2;

    logic [3:0]        op_raw;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [7:0]        off;
    logic              is_branch;
    logic              is_illegal;
    logic              is_add;
    logic              trap;
    logic              wr_en;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [PC_W-1:0]   next_pc;

    assign op_raw     = instr_p0[OP_MSB:OP_LSB];
    assign rd         = instr_p0[RD_MSB:RD_LSB];
    assign rs1        = instr_p0[RS1_MSB:RS1_LSB];
    assign rs2        = instr_p0[RS2_MSB:RS2_LSB];
    assign off        = instr_p0[OFF_MSB:OFF_LSB];
    assign is_branch  = is_branch_op(op_raw);
    assign is_illegal = op_raw > OP_LAST_LEGAL;
    assign is_add     = op_raw == OP_ADD;

`ifdef TRAP_ON_OVF_EN
    assign trap = is_add && ovf_p2;
`else
    assign trap = 1'b0;
`endif

    // Branches, illegal ops and trapped ADDs leave the register file alone.
    assign wr_en = (state == ST_WRITEBACK) && !is_branch && !is_illegal && !trap;

    // Taken branches add the sign-extended offset; everything else steps by one.
    assign next_pc = (is_branch && take_p2) ? pc + PC_W'($signed(off))
                                            : pc + PC_W'(1);

    reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (is_branch ? rd : rs1),
        .rb_addr (rs2),
        .ra_data (rdata_a),
        .rb_data (rdata_b),
        .we      (wr_en),
        .waddr   (rd),
        .wdata   (res_p2)
    );

    // Sequencer FSM with registered handshake, ALU drive and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            instr_ready <= 1'b0;
            instr_p0    <= '0;
            pc          <= PC_W'(RESET_PC);
            alu_a       <= '0;
            alu_b       <= '0;
            alu_s       <= '0;
            res_p2      <= '0;
            take_p2     <= 1'b0;
            ovf_p2      <= 1'b0;
            ovf_flag    <= 1'b0;
            illegal     <= 1'b0;
`ifdef TRAP_ON_OVF_EN
            halted      <= 1'b0;
`endif
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (instr_valid && instr_ready) begin
                        instr_p0    <= instr;
                        instr_ready <= 1'b0;
                        state       <= ST_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    // Operands are latched here, so rd may alias rs1/rs2 safely.
                    if (!is_illegal) begin
                        alu_a <= rdata_a;
                        alu_b <= is_branch ? '0 : rdata_b;
                        alu_s <= op_raw;
                    end
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    res_p2  <= alu_f;
                    take_p2 <= alu_take_branch;
                    ovf_p2  <= alu_ovf;
                    illegal <= is_illegal;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_s   <= '0;
                    state   <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    if (is_add && ovf_p2) begin
                        ovf_flag <= 1'b1;
                    end
                    if (trap) begin
`ifdef TRAP_ON_OVF_EN
                        state  <= ST_HALT;
                        halted <= 1'b1;
`endif
                    end else begin
                        pc          <= next_pc;
                        instr_ready <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
`ifdef TRAP_ON_OVF_EN
                ST_HALT: begin
                    state <= ST_HALT;
                end
`endif
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifndef TRAP_ON_OVF_EN
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with a behavioural 16-bit ALU.
// Register contents are observed through the ALU operands of later instructions.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [7:0]  pc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_s;
    logic [15:0] alu_f;
    logic        alu_take_branch;
    logic        alu_ovf;
    logic        ovf_flag;
    logic        illegal;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [3:0]  ex_s;
    int          ill_cnt;
    int          stray;
    int          ready_err;
    logic        wb_ill;
    logic [7:0]  exp_pc;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(16), .PC_W(8), .RESET_PC(0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .pc              (pc),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_s           (alu_s),
        .alu_f           (alu_f),
        .alu_take_branch (alu_take_branch),
        .alu_ovf         (alu_ovf),
        .ovf_flag        (ovf_flag),
        .illegal         (illegal),
        .halted          (halted)
    );

    // Behavioural ALU: shift amounts use b[3:0]; branches compare a with b.
    always_comb begin
        alu_f           = '0;
        alu_take_branch = 1'b0;
        alu_ovf         = 1'b0;
        case (alu_s)
            4'd0: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_f[15] != alu_a[15]);
            end
            4'd1: alu_f = ~alu_b;
            4'd2: alu_f = alu_a & alu_b;
            4'd3: alu_f = alu_a | alu_b;
            4'd4: alu_f = 16'($signed(alu_a) >>> alu_b[3:0]);
            4'd5: alu_f = alu_a << alu_b[3:0];
            4'd6: alu_take_branch = (alu_a == alu_b);
            4'd7: alu_take_branch = (alu_a != alu_b);
            4'd8: alu_f = alu_a ^ alu_b;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Issue one instruction and sample the four cycles that follow the accept.
    task automatic run_instr(input logic [15:0] ins);
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", 32'(instr_ready), 1);
        instr       = ins;
        instr_valid = 1'b1;
        ill_cnt     = 0;
        stray       = 0;
        ready_err   = 0;
        wb_ill      = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            if (illegal) ill_cnt++;
            if (c == 2) begin
                ex_a = alu_a;
                ex_b = alu_b;
                ex_s = alu_s;
            end else if (alu_s != 4'd0 || alu_a != 16'd0 || alu_b != 16'd0) begin
                stray++;
            end
            if (c == 3) wb_ill = illegal;
            if ((c == 4) != instr_ready) ready_err++;
        end
    endtask

    task automatic step(input string tag, input logic [15:0] ins, input logic [7:0] want_pc);
        run_instr(ins);
        chk({tag, "_pc"}, 32'(pc), 32'(want_pc));
        chk({tag, "_cycles"}, 32'(ready_err), 0);
        chk({tag, "_idle_alu"}, 32'(stray), 0);
        exp_pc = want_pc;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_alu_s", 32'(alu_s), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_ovf_flag", 32'(ovf_flag), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_halted", 32'(halted), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_low_after_release", 32'(instr_ready), 0);
        @(posedge clk); #1;
        chk("ready_first_edge", 32'(instr_ready), 1);

        // 1) seed r1 = 5, then r3 = r1 + r1
        exp_pc = 8'h00;
        step("inv_r1", 16'h1100, 8'h01);
        chk("inv_sel", 32'(ex_s), 1);
        step("add_r2", 16'h0211, 8'h02);
        step("inv_r3", 16'h1302, 8'h03);
        chk("inv_r3_b", 32'(ex_b), 'hFFFE);
        step("add_r4a", 16'h0433, 8'h04);
        step("add_r4b", 16'h0444, 8'h05);
        step("add_r1", 16'h0143, 8'h06);
        chk("add_r1_a", 32'(ex_a), 4);
        chk("add_r1_b", 32'(ex_b), 1);
        step("add_r3", 16'h0311, 8'h07);
        chk("add_r3_a", 32'(ex_a), 5);
        chk("add_r3_b", 32'(ex_b), 5);
        chk("add_r3_sel", 32'(ex_s), 0);
        step("rd_r3", 16'h3630, 8'h08);
        chk("r3_value", 32'(ex_a), 'h000A);
        chk("or_sel", 32'(ex_s), 3);
        chk("ovf_flag_clear", 32'(ovf_flag), 0);

        // 2) r1 = 0x7FFF, ADD r9,r1,r1 overflows
        step("inv_r8", 16'h1800, 8'h09);
        step("sll_r7", 16'h5788, 8'h0A);
        chk("sll_sel", 32'(ex_s), 5);
        step("inv_r1b", 16'h1107, 8'h0B);
        chk("r7_value", 32'(ex_b), 'h8000);
        run_instr(16'h0911);
        chk("ovf_add_a", 32'(ex_a), 'h7FFF);
        chk("ovf_flag_set", 32'(ovf_flag), 1);
`ifdef TRAP_ON_OVF_EN
        chk("trap_halted", 32'(halted), 1);
        chk("trap_pc_hold", 32'(pc), 'h0B);
        instr       = 16'h3690;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("trap_ready_low", 32'(instr_ready), 0);
        end
        instr_valid = 1'b0;
        chk("trap_pc_still", 32'(pc), 'h0B);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_halted", 32'(halted), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        exp_pc = 8'h00;
`else
        chk("ovf_pc", 32'(pc), 'h0C);
        chk("ovf_no_halt", 32'(halted), 0);
        exp_pc = 8'h0C;
        step("rd_r9", 16'h3690, 8'h0D);
        chk("r9_wrapped_sum", 32'(ex_a), 'hFFFE);
`endif
        // re-seed r1 = 0xFFFF, r2 = 0xFFFE for both builds
        step("reseed_r1", 16'h1100, exp_pc + 8'd1);
        step("reseed_r2", 16'h0211, exp_pc + 8'd1);

        // 3) branches
        step("and_r4", 16'h2400, exp_pc + 8'd1);
        step("jmp_20", {8'h60, 8'(8'h20 - exp_pc)}, 8'h20);
        chk("beq_sel", 32'(ex_s), 6);
        step("beq_taken", 16'h6410, 8'h30);
        chk("beq_a", 32'(ex_a), 0);
        chk("beq_b", 32'(ex_b), 0);
        step("inv_r4", 16'h1402, 8'h31);
        step("jmp_05", 16'h60D4, 8'h05);
        step("bne_wrap", 16'h74F0, 8'hF5);
        chk("bne_a", 32'(ex_a), 1);
        step("bne_not_taken", 16'h7040, 8'hF6);
        step("beq_not_taken", 16'h6420, 8'hF7);
        step("jmp_ff", 16'h6008, 8'hFF);
        step("pc_wrap", 16'h8544, 8'h00);
        chk("xor_sel", 32'(ex_s), 8);

        // 4) illegal opcode
        step("illegal_op", 16'hC123, 8'h01);
        chk("illegal_pulses", 32'(ill_cnt), 1);
        chk("illegal_in_wb", 32'(wb_ill), 1);
        chk("illegal_sel", 32'(ex_s), 0);
        chk("illegal_a", 32'(ex_a), 0);
        step("rd_r1", 16'h3610, 8'h02);
        chk("r1_untouched", 32'(ex_a), 'hFFFF);
        chk("no_illegal", 32'(ill_cnt), 0);

        // 5) idle FETCH, write to r0
        instr = 16'h0144;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_pc", 32'(pc), 2);
            chk("idle_ready", 32'(instr_ready), 1);
            chk("idle_sel", 32'(alu_s), 0);
        end
        step("add_r0", 16'h0044, 8'h03);
        step("rd_r0", 16'h3604, 8'h04);
        chk("r0_zero", 32'(ex_a), 0);
        chk("r4_one", 32'(ex_b), 1);

        // 6) reset during EXECUTE
        instr       = 16'h0544;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("exec_before_rst", 32'(alu_a), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", 32'(alu_a), 0);
        chk("mid_rst_b", 32'(alu_b), 0);
        chk("mid_rst_s", 32'(alu_s), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_ready", 32'(instr_ready), 0);
        chk("mid_rst_ovf", 32'(ovf_flag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rd_r5", 16'h3650, 8'h01);
        chk("r5_not_written", 32'(ex_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck handshake.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
